path_tracer: RTL and testbench

//  Reads the predecessor vector written by the visited/prev store after a Dijkstra run.

---
 rtl/path_tracer_pkg.sv | 18 +
 rtl/path_tracer.sv | 162 ++++++++++++++++
 tb/tb_path_tracer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/path_tracer_pkg.sv
// -----------------------------------------------------------------------------
// path_tracer_pkg
//   Shared constants and types for the path tracer.
//   - DEFAULT_MAX_NODES / DEFAULT_INDEX_WIDTH : default sizing of the prev store
//   - tracer_state_t                          : controller state encoding
// -----------------------------------------------------------------------------
package path_tracer_pkg;

  localparam int DEFAULT_MAX_NODES   = 8;
  localparam int DEFAULT_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } tracer_state_t;

endpackage

// File: rtl/path_tracer.sv
// -----------------------------------------------------------------------------
// path_tracer
//   Walks the predecessor vector left behind by a Dijkstra run, starting at a
//   requested destination and following prev[] links back to the source. The
//   path is emitted one node per beat on a valid/ready stream, destination
//   first and source last. The prev store is only read, never written.
//
// Ports
//   clock                  in   single clock, all state on posedge
//   reset                  in   synchronous, active-high
//   start                  in   request a trace (accepted only when idle)
//   source                 in   path origin node
//   dest                   in   path end node (emitted first)
//   number_of_nodes        in   active node count
//   prev_vector_flattened  in   entry j at [INDEX_WIDTH*j +: INDEX_WIDTH]
//   busy                   out  high while beats are being emitted
//   path_node              out  current path node
//   path_valid             out  path_node is valid
//   path_ready             in   consumer accepts beat when valid & ready
//   path_last              out  beat carries the source node
//   path_length            out  nodes emitted so far this trace
//   done                   out  one-cycle pulse at trace end
//   error                  out  qualified by done: unreachable/loop/bad index
// -----------------------------------------------------------------------------
module path_tracer
  import path_tracer_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INDEX_WIDTH-1:0]           source,
  input  logic [INDEX_WIDTH-1:0]           dest,
  input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic                             busy,
  output logic [INDEX_WIDTH-1:0]           path_node,
  output logic                             path_valid,
  input  logic                             path_ready,
  output logic                             path_last,
  output logic [INDEX_WIDTH:0]             path_length,
  output logic                             done,
  output logic                             error
);

  // Code written by the store for a node that was never reached.
  localparam logic [INDEX_WIDTH-1:0] UNVISITED = {INDEX_WIDTH{1'b1}};
  // Physical capacity of the prev vector, widened so MAX_NODES = 2^W fits.
  localparam logic [INDEX_WIDTH:0]   CAPACITY  = MAX_NODES[INDEX_WIDTH:0];

  tracer_state_t          state_reg, state_next;
  logic [INDEX_WIDTH-1:0] cur_reg, cur_next;
  logic [INDEX_WIDTH-1:0] source_reg, source_next;
  logic [INDEX_WIDTH:0]   hops_reg, hops_next;
  logic [INDEX_WIDTH:0]   length_reg, length_next;
  logic                   err_reg, err_next;

  logic [INDEX_WIDTH-1:0] prev_entry;
  logic [INDEX_WIDTH:0]   hops_plus1;
  logic                   handshake;

  // An index is usable only if it names an active node that also exists in
  // the physical prev vector.
  function automatic logic index_in_range(input logic [INDEX_WIDTH-1:0] idx,
                                          input logic [INDEX_WIDTH-1:0] n);
    return (idx < n) && ({1'b0, idx} < CAPACITY);
  endfunction

  // cur_reg is only used as an index while in EMIT, where it is always in range.
  assign prev_entry = prev_vector_flattened[INDEX_WIDTH*cur_reg +: INDEX_WIDTH];
  assign hops_plus1 = hops_reg + 1'b1;
  assign handshake  = (state_reg == EMIT) && path_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cur_reg    <= '0;
      source_reg <= '0;
      hops_reg   <= '0;
      length_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cur_reg    <= cur_next;
      source_reg <= source_next;
      hops_reg   <= hops_next;
      length_reg <= length_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cur_next    = cur_reg;
    source_next = source_reg;
    hops_next   = hops_reg;
    length_next = length_reg;
    err_next    = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          source_next = source;
          cur_next    = dest;
          hops_next   = '0;
          length_next = '0;
          if (!index_in_range(dest, number_of_nodes) ||
              !index_in_range(source, number_of_nodes)) begin
            state_next = FIN;
            err_next   = 1'b1;
          end else begin
            state_next = EMIT;
            err_next   = 1'b0;
          end
        end
      end

      EMIT: begin
        if (handshake) begin
          hops_next   = hops_plus1;
          length_next = hops_plus1;
          if (cur_reg == source_reg) begin
            state_next = FIN;
            err_next   = 1'b0;
          end else if (prev_entry == UNVISITED ||
                       !index_in_range(prev_entry, number_of_nodes)) begin
            state_next = FIN;
            err_next   = 1'b1;
          end else if (hops_plus1 == {1'b0, number_of_nodes}) begin
            // A legal path visits each node at most once, so N beats
            // without reaching the source means the prev links loop.
            state_next = FIN;
            err_next   = 1'b1;
          end else begin
            cur_next = prev_entry;
          end
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All outputs decode from registered state, so path_valid rises the cycle
  // after start and the beat stays stable while the consumer stalls.
  assign busy        = (state_reg == EMIT);
  assign path_valid  = (state_reg == EMIT);
  assign path_node   = cur_reg;
  assign path_last   = (state_reg == EMIT) && (cur_reg == source_reg);
  assign path_length = length_reg;
  assign done        = (state_reg == FIN);
  assign error       = (state_reg == FIN) && err_reg;

endmodule

// File: tb/tb_path_tracer.sv
module tb_path_tracer;

  localparam int MN = 8;
  localparam int IW = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [IW-1:0]    source;
  logic [IW-1:0]    dest;
  logic [IW-1:0]    number_of_nodes;
  logic [IW*MN-1:0] prev_vector_flattened;
  logic             busy;
  logic [IW-1:0]    path_node;
  logic             path_valid;
  logic             path_ready;
  logic             path_last;
  logic [IW:0]      path_length;
  logic             done;
  logic             error;

  path_tracer #(.MAX_NODES(MN), .INDEX_WIDTH(IW)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .source                (source),
    .dest                  (dest),
    .number_of_nodes       (number_of_nodes),
    .prev_vector_flattened (prev_vector_flattened),
    .busy                  (busy),
    .path_node             (path_node),
    .path_valid            (path_valid),
    .path_ready            (path_ready),
    .path_last             (path_last),
    .path_length           (path_length),
    .done                  (done),
    .error                 (error)
  );

  always #5 clock = ~clock;

  // prev vectors, entry 7 in the top nibble, entry 0 in the bottom; F = unvisited
  localparam logic [31:0] PREV_CHAIN = 32'hFFF2_110F; // 0:U 1:0 2:1 3:1 4:2
  localparam logic [31:0] PREV_HOLE  = 32'hFFF2_F10F; // as chain, prev[3]=U
  localparam logic [31:0] PREV_LOOP  = 32'hFFFF_F12F; // 1:2 2:1, others U

  typedef struct {
    logic [IW-1:0] node;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int node, input logic last);
    beat_t b;
    b.node = node[IW-1:0];
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Runs one trace; ready_mode 0 = always ready, 1 = toggling.
  // inject_start pulses start again while busy to show it is ignored.
  task automatic run_trace(input string name, input int src, input int dst,
                           input int ready_mode, input bit inject_start,
                           input logic exp_err, input int exp_len);
    bit    seen_done = 0;
    bit    holding   = 0;
    int    held_node = 0;
    int    beats     = 0;
    int    cyc       = 0;
    beat_t b;
    @(negedge clock);
    source = src[IW-1:0];
    dest   = dst[IW-1:0];
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!seen_done && cyc < 200) begin
      path_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
      start      = inject_start && (cyc == 2);
      #1;
      if (done) begin
        seen_done = 1;
        check({name, "_error"}, error, exp_err);
        check({name, "_length"}, path_length, exp_len);
        check({name, "_leftover"}, exp_q.size(), 0);
      end else if (path_valid) begin
        if (holding) check({name, "_hold"}, path_node, held_node);
        if (path_ready) begin
          holding = 0;
          check({name, "_len_run"}, path_length, beats);
          if (exp_q.size() == 0) begin
            check({name, "_extra_beat"}, path_node, 99);
          end else begin
            b = exp_q.pop_front();
            check({name, "_node"}, path_node, b.node);
            check({name, "_last"}, path_last, b.last);
          end
          $display("%s beat %0d node=%0d last=%0d", name, beats, path_node, path_last);
          beats++;
        end else begin
          holding   = 1;
          held_node = path_node;
        end
      end
      cyc++;
      @(negedge clock);
    end
    start = 1'b0;
    if (!seen_done) check({name, "_timeout"}, 0, 1);
    #1;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_valid_after"}, path_valid, 0);
    check({name, "_len_hold"}, path_length, exp_len);
    $display("%s done error=%0d length=%0d beats=%0d", name, exp_err, exp_len, beats);
    exp_q.delete();
  endtask

  initial begin
    bit saw_done;
    bit reached;
    reset                 = 1'b1;
    start                 = 1'b1;   // start alongside reset must lose
    source                = '0;
    dest                  = 4'd4;
    number_of_nodes       = 4'd5;
    prev_vector_flattened = PREV_CHAIN;
    path_ready            = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", path_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_node", path_node, 0);
    check("rst_length", path_length, 0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("rst_idle", busy, 0);

    // 1: straight chain, always ready
    prev_vector_flattened = PREV_CHAIN;
    push(4, 0); push(2, 0); push(1, 0); push(0, 1);
    run_trace("chain", 0, 4, 0, 0, 1'b0, 4);

    // 2: same, consumer stalls every other cycle
    push(4, 0); push(2, 0); push(1, 0); push(0, 1);
    run_trace("chain_stall", 0, 4, 1, 0, 1'b0, 4);

    // 3: unreachable predecessor
    prev_vector_flattened = PREV_HOLE;
    push(3, 0);
    run_trace("unreach", 0, 3, 0, 0, 1'b1, 1);

    // 4: loop guard stops after N beats
    prev_vector_flattened = PREV_LOOP;
    push(1, 0); push(2, 0); push(1, 0); push(2, 0); push(1, 0);
    run_trace("loop", 0, 1, 0, 0, 1'b1, 5);

    // 5: bad destination, then dest == source
    prev_vector_flattened = PREV_CHAIN;
    run_trace("bad_dest", 0, 6, 0, 0, 1'b1, 0);
    push(2, 1);
    run_trace("self", 2, 2, 0, 0, 1'b0, 1);

    // 6: reset in the middle of the chain trace
    @(negedge clock);
    source     = '0;
    dest       = 4'd4;
    path_ready = 1'b1;
    start      = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      #1;
      if (path_valid && path_node == 4'd2) reached = 1;
      else @(negedge clock);
    end
    check("mid_reach", reached, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_busy", busy, 0);
    check("mid_valid", path_valid, 0);
    check("mid_last", path_last, 0);
    check("mid_node", path_node, 0);
    check("mid_length", path_length, 0);
    check("mid_done", done, 0);
    @(negedge clock);
    reset    = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      if (done) saw_done = 1;
    end
    check("mid_no_done", saw_done, 0);
    $display("reset abort checked");

    // fresh trace after reset, with a stray start while busy
    push(4, 0); push(2, 0); push(1, 0); push(0, 1);
    run_trace("restart", 0, 4, 0, 1, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
